// File: rtl/anita3_evhdr_pkg.sv
// Shared types, constants and header-word formatter for the ANITA-3 event header writer.
package anita3_evhdr_pkg;

    localparam int unsigned HDR_WORDS = 8;
    localparam logic [3:0]  HDR_TAG   = 4'hA;

    localparam logic [2:0] W_TAG     = 3'd0;
    localparam logic [2:0] W_CNT_LO  = 3'd1;
    localparam logic [2:0] W_CNT_HI  = 3'd2;
    localparam logic [2:0] W_TIME_LO = 3'd3;
    localparam logic [2:0] W_TIME_HI = 3'd4;
    localparam logic [2:0] W_PATTERN = 3'd5;
    localparam logic [2:0] W_DROPS   = 3'd6;
    localparam logic [2:0] W_CSUM    = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } evhdr_state_e;

    typedef struct packed {
        logic [7:0]  trig_type;
        logic [31:0] trig_time;
        logic [15:0] pattern;
        logic [31:0] event_num;
        logic [15:0] drops;
    } evhdr_fields_t;

    // Header word selected by index; checksum word supplied by caller.
    function automatic logic [15:0] hdr_word(input evhdr_fields_t f,
                                             input logic [1:0]    buf_idx,
                                             input logic [2:0]    idx,
                                             input logic [15:0]   csum);
        case (idx)
            W_TAG:     return {HDR_TAG, 2'b00, buf_idx, f.trig_type};
            W_CNT_LO:  return f.event_num[15:0];
            W_CNT_HI:  return f.event_num[31:16];
            W_TIME_LO: return f.trig_time[15:0];
            W_TIME_HI: return f.trig_time[31:16];
            W_PATTERN: return f.pattern;
            W_DROPS:   return f.drops;
            default:   return csum;
        endcase
    endfunction

endpackage

// File: rtl/anita3_evhdr_checksum.sv
// 16-bit running-XOR accumulator; clr restarts the sum, optionally seeding it with din.
module anita3_evhdr_checksum
    import anita3_evhdr_pkg::*;
(
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sum
);

    logic [15:0] sum_q;

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= (clr ? 16'h0000 : sum_q) ^ (en ? din : 16'h0000);
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/anita3_event_header_writer.sv
// Event header writer: allocates a buffer per trigger, writes 8 header words, tracks occupancy.
// Optional EVENT_HEADER_CHECKSUM_EN puts the XOR of words 0..6 in word 7 (otherwise 0).
module anita3_event_header_writer
    import anita3_evhdr_pkg::*;
#(
    parameter int unsigned NUM_BUFFERS = 4
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        trig_i,
    input  logic [7:0]  trig_type_i,
    input  logic [31:0] trig_time_i,
    input  logic [15:0] trig_pattern_i,
    input  logic        buf_release_i,
    output logic [7:0]  event_wr_addr_o,
    output logic [15:0] event_wr_dat_o,
    output logic        event_wr_o,
    output logic        event_done_o,
    output logic        busy_o,
    output logic        full_o,
    output logic [2:0]  occupancy_o,
    output logic [31:0] event_count_o,
    output logic [15:0] drop_count_o,
    output logic        release_err_o
);

    evhdr_state_e  state_q, state_d;
    logic [2:0]    word_q, word_d;
    logic [1:0]    cur_buf_q, cur_buf_d;
    logic [1:0]    next_buf_q, next_buf_d;
    evhdr_fields_t fields_q, fields_d, fresh_c;
    logic [31:0]   ev_cnt_q, ev_cnt_d;
    logic [15:0]   drop_q, drop_d;
    logic [2:0]    occ_q, occ_d;
    logic          full_q, full_d;
    logic          rel_err_q, rel_err_d;
    logic [7:0]    addr_q, addr_d;
    logic [15:0]   dat_q, dat_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [15:0]   csum_c;
    logic          accept_c, drop_c, fill_c;

    assign accept_c = (state_q == IDLE) && trig_i && !full_q;
    assign drop_c   = trig_i && !accept_c;
    assign fill_c   = (state_q == DONE);
    assign fresh_c  = '{trig_type: trig_type_i, trig_time: trig_time_i,
                        pattern: trig_pattern_i, event_num: ev_cnt_q, drops: drop_q};

`ifdef EVENT_HEADER_CHECKSUM_EN
    logic csum_en_c;
    // Fold in every emitted word except the checksum slot itself.
    assign csum_en_c = wr_d && (addr_d[2:0] != W_CSUM);

    anita3_evhdr_checksum u_csum (
        .clk33_i (clk33_i),
        .rst_n_i (rst_n_i),
        .clr     (accept_c),
        .en      (csum_en_c),
        .din     (dat_d),
        .sum     (csum_c)
    );
`else
    assign csum_c = 16'h0000;
`endif

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cur_buf_d  = cur_buf_q;
        next_buf_d = next_buf_q;
        fields_d   = fields_q;
        ev_cnt_d   = ev_cnt_q;
        rel_err_d  = rel_err_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = WRITE;
                    word_d    = W_TAG;
                    cur_buf_d = next_buf_q;
                    fields_d  = fresh_c;
                    wr_d      = 1'b1;
                    busy_d    = 1'b1;
                    addr_d    = {next_buf_q, 6'd0};
                    dat_d     = hdr_word(fresh_c, next_buf_q, W_TAG, csum_c);
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (word_q == W_CSUM) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    addr_d  = {cur_buf_q, 6'd0};
                end else begin
                    word_d = word_q + 3'd1;
                    wr_d   = 1'b1;
                    addr_d = {cur_buf_q, 3'b000, word_d};
                    dat_d  = hdr_word(fields_q, cur_buf_q, word_d, csum_c);
                end
            end
            DONE: begin
                state_d    = IDLE;
                ev_cnt_d   = ev_cnt_q + 32'd1;
                next_buf_d = (next_buf_q == 2'(NUM_BUFFERS - 1)) ? 2'd0 : next_buf_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase

        drop_d = (drop_c && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        // A release at zero occupancy is ignored but flagged.
        if (buf_release_i && (occ_q == 3'd0)) begin
            rel_err_d = 1'b1;
            occ_d     = occ_q + {2'b00, fill_c};
        end else if (buf_release_i) begin
            occ_d = occ_q + {2'b00, fill_c} - 3'd1;
        end else begin
            occ_d = occ_q + {2'b00, fill_c};
        end
        full_d = (occ_d == 3'(NUM_BUFFERS));
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            word_q     <= 3'd0;
            cur_buf_q  <= 2'd0;
            next_buf_q <= 2'd0;
            fields_q   <= '0;
            ev_cnt_q   <= 32'd0;
            drop_q     <= 16'd0;
            occ_q      <= 3'd0;
            full_q     <= 1'b0;
            rel_err_q  <= 1'b0;
            addr_q     <= 8'd0;
            dat_q      <= 16'd0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            cur_buf_q  <= cur_buf_d;
            next_buf_q <= next_buf_d;
            fields_q   <= fields_d;
            ev_cnt_q   <= ev_cnt_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            full_q     <= full_d;
            rel_err_q  <= rel_err_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign event_wr_addr_o = addr_q;
    assign event_wr_dat_o  = dat_q;
    assign event_wr_o      = wr_q;
    assign event_done_o    = done_q;
    assign busy_o          = busy_q;
    assign full_o          = full_q;
    assign occupancy_o     = occ_q;
    assign event_count_o   = ev_cnt_q;
    assign drop_count_o    = drop_q;
    assign release_err_o   = rel_err_q;

endmodule

// File: tb/tb_anita3_event_header_writer.sv
// Bench for the event header writer: a 4-buffer and a 2-buffer instance checked against a transaction model.
module tb_anita3_event_header_writer;

    localparam int unsigned NI = 2;

    logic        clk33_i = 1'b0;
    logic        rst_n_i;
    logic        trig_i;
    logic [7:0]  trig_type_i;
    logic [31:0] trig_time_i;
    logic [15:0] trig_pattern_i;
    logic        buf_release_i;

    logic [7:0]  addr_o [NI];
    logic [15:0] dat_o  [NI];
    logic        wr_o   [NI];
    logic        done_o [NI];
    logic        busy_o [NI];
    logic        full_o [NI];
    logic [2:0]  occ_o  [NI];
    logic [31:0] evc_o  [NI];
    logic [15:0] drc_o  [NI];
    logic        err_o  [NI];

    int unsigned nbufs [NI] = '{4, 2};

    // Behavioural model state per instance.
    int          m_occ  [NI];
    logic [1:0]  m_nbuf [NI];
    logic [31:0] m_evc  [NI];
    logic [15:0] m_drc  [NI];
    bit          m_err  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #15 clk33_i = ~clk33_i;

    anita3_event_header_writer #(.NUM_BUFFERS(4)) u_dut4 (
        .clk33_i(clk33_i), .rst_n_i(rst_n_i), .trig_i(trig_i), .trig_type_i(trig_type_i),
        .trig_time_i(trig_time_i), .trig_pattern_i(trig_pattern_i), .buf_release_i(buf_release_i),
        .event_wr_addr_o(addr_o[0]), .event_wr_dat_o(dat_o[0]), .event_wr_o(wr_o[0]),
        .event_done_o(done_o[0]), .busy_o(busy_o[0]), .full_o(full_o[0]), .occupancy_o(occ_o[0]),
        .event_count_o(evc_o[0]), .drop_count_o(drc_o[0]), .release_err_o(err_o[0])
    );

    anita3_event_header_writer #(.NUM_BUFFERS(2)) u_dut2 (
        .clk33_i(clk33_i), .rst_n_i(rst_n_i), .trig_i(trig_i), .trig_type_i(trig_type_i),
        .trig_time_i(trig_time_i), .trig_pattern_i(trig_pattern_i), .buf_release_i(buf_release_i),
        .event_wr_addr_o(addr_o[1]), .event_wr_dat_o(dat_o[1]), .event_wr_o(wr_o[1]),
        .event_done_o(done_o[1]), .busy_o(busy_o[1]), .full_o(full_o[1]), .occupancy_o(occ_o[1]),
        .event_count_o(evc_o[1]), .drop_count_o(drc_o[1]), .release_err_o(err_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_occ[i] = 0; m_nbuf[i] = 2'd0; m_evc[i] = 32'd0; m_drc[i] = 16'd0; m_err[i] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(addr_o[i]), 32'd0);
            check($sformatf("%s_dat%0d", tag, i), 32'(dat_o[i]), 32'd0);
            check($sformatf("%s_ctl%0d", tag, i),
                  32'({wr_o[i], done_o[i], busy_o[i], full_o[i], err_o[i]}), 32'd0);
            check($sformatf("%s_occ%0d", tag, i), 32'(occ_o[i]), 32'd0);
            check($sformatf("%s_evc%0d", tag, i), evc_o[i], 32'd0);
            check($sformatf("%s_drc%0d", tag, i), 32'(drc_o[i]), 32'd0);
        end
    endtask

    // One 11-cycle window: optional trigger at cycle 0, optional busy-time trigger, optional release.
    task automatic run_event(input bit trig, input logic [7:0] ty, input logic [31:0] tm,
                             input logic [15:0] pat, input int extra_cyc, input int rel_cyc);
        bit          acc [NI];
        logic [1:0]  ab  [NI];
        logic [15:0] w   [NI][8];
        bit          all_acc;
        bit          ew, ed, eb, fill;
        for (int i = 0; i < NI; i++) begin
            acc[i] = trig && (m_occ[i] != int'(nbufs[i]));
            ab[i]  = m_nbuf[i];
            w[i][0] = {4'hA, 2'b00, ab[i], ty};
            w[i][1] = m_evc[i][15:0];
            w[i][2] = m_evc[i][31:16];
            w[i][3] = tm[15:0];
            w[i][4] = tm[31:16];
            w[i][5] = pat;
            w[i][6] = m_drc[i];
            w[i][7] = 16'h0000;
`ifdef EVENT_HEADER_CHECKSUM_EN
            for (int k = 0; k < 7; k++) w[i][7] = w[i][7] ^ w[i][k];
`endif
        end
        all_acc = acc[0] && acc[1];
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk33_i);
            for (int i = 0; i < NI; i++) begin
                ew = acc[i] && (c >= 1) && (c <= 8);
                ed = acc[i] && (c == 9);
                eb = acc[i] && (c >= 1) && (c <= 9);
                check($sformatf("wr%0d_c%0d", i, c), 32'(wr_o[i]), 32'(ew));
                check($sformatf("done%0d_c%0d", i, c), 32'(done_o[i]), 32'(ed));
                check($sformatf("busy%0d_c%0d", i, c), 32'(busy_o[i]), 32'(eb));
                if (ew) begin
                    check($sformatf("addr%0d_w%0d", i, c - 1), 32'(addr_o[i]), 32'({ab[i], 6'(c - 1)}));
                    check($sformatf("dat%0d_w%0d", i, c - 1), 32'(dat_o[i]), 32'(w[i][c - 1]));
                end
                if (ed) check($sformatf("done_addr%0d", i), 32'(addr_o[i]), 32'({ab[i], 6'd0}));
                check($sformatf("occ%0d_c%0d", i, c), 32'(occ_o[i]), 32'(m_occ[i]));
                check($sformatf("full%0d_c%0d", i, c), 32'(full_o[i]), 32'(m_occ[i] == int'(nbufs[i])));
                check($sformatf("evc%0d_c%0d", i, c), evc_o[i], m_evc[i]);
                check($sformatf("drc%0d_c%0d", i, c), 32'(drc_o[i]), 32'(m_drc[i]));
                check($sformatf("err%0d_c%0d", i, c), 32'(err_o[i]), 32'(m_err[i]));
            end
            trig_i         = (c == 0 && trig) || (c == extra_cyc && all_acc);
            trig_type_i    = ty;
            trig_time_i    = tm;
            trig_pattern_i = pat;
            buf_release_i  = (c == rel_cyc);
            // Model effect of the clock edge closing cycle c.
            for (int i = 0; i < NI; i++) begin
                if ((c == 0 && trig && !acc[i]) || (c == extra_cyc && all_acc && c >= 1))
                    if (m_drc[i] != 16'hFFFF) m_drc[i] = m_drc[i] + 16'd1;
                fill = acc[i] && (c == 9);
                if (fill) begin
                    m_nbuf[i] = (int'(m_nbuf[i]) == int'(nbufs[i]) - 1) ? 2'd0 : m_nbuf[i] + 2'd1;
                    m_evc[i]  = m_evc[i] + 32'd1;
                end
                if (c == rel_cyc && m_occ[i] == 0) begin
                    m_err[i] = 1'b1;
                    m_occ[i] = m_occ[i] + int'(fill);
                end else if (c == rel_cyc) begin
                    m_occ[i] = m_occ[i] + int'(fill) - 1;
                end else begin
                    m_occ[i] = m_occ[i] + int'(fill);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk33_i);
        rst_n_i = 1'b0;
        trig_i = 1'b0;
        buf_release_i = 1'b0;
        #1;
        check_all_zero("reset");
        model_reset();
        @(negedge clk33_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        int r, rel, extra;
        rst_n_i = 1'b0;
        trig_i = 1'b0;
        trig_type_i = 8'd0;
        trig_time_i = 32'd0;
        trig_pattern_i = 16'd0;
        buf_release_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk33_i);
        check_all_zero("por");
        rst_n_i = 1'b1;

        // Directed single trigger, then fill both instances until they drop.
        run_event(1'b1, 8'h5C, 32'h12345678, 16'hBEEF, -1, -1);
        for (int k = 0; k < 4; k++)
            run_event(1'b1, 8'(8'h10 + k), $urandom, 16'($urandom), -1, -1);
        check("full4_final", 32'(full_o[0]), 32'd1);
        check("drops4_final", 32'(drc_o[0]), 32'd1);

        // Two releases to occupancy 2, then a release coincident with DONE.
        run_event(1'b0, 8'h00, 32'h0, 16'h0, -1, 0);
        run_event(1'b0, 8'h00, 32'h0, 16'h0, -1, 0);
        run_event(1'b1, 8'h77, 32'hCAFEF00D, 16'h1234, -1, 9);
        check("occ_coincident", 32'(occ_o[0]), 32'd2);
        for (int k = 0; k < 3; k++) run_event(1'b0, 8'h00, 32'h0, 16'h0, -1, 0);
        check("release_err_sticky", 32'(err_o[0]), 32'd1);

        // Busy-time trigger drop, then buffer rotation with one release.
        do_reset();
        run_event(1'b1, 8'hA1, 32'h00000001, 16'h0001, 3, -1);
        run_event(1'b1, 8'hA2, 32'h00000002, 16'h0002, -1, -1);
        run_event(1'b0, 8'h00, 32'h0, 16'h0, -1, 0);
        run_event(1'b1, 8'hA3, 32'h00000003, 16'h0003, -1, -1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 14);
            rel = (r <= 10) ? r : -1;
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            run_event($urandom_range(0, 3) != 0, 8'($urandom), $urandom, 16'($urandom), extra, rel);
        end

        // Reset asserted while word 4 is on the bus.
        do_reset();
        run_event(1'b0, 8'h00, 32'h0, 16'h0, -1, -1);
        @(negedge clk33_i);
        trig_i = 1'b1;
        trig_type_i = 8'h3C;
        trig_time_i = 32'h89ABCDEF;
        trig_pattern_i = 16'h5555;
        @(negedge clk33_i);
        trig_i = 1'b0;
        repeat (4) @(negedge clk33_i);
        check("midwrite_wr_before", 32'(wr_o[0]), 32'd1);
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midwrite");
        model_reset();
        @(negedge clk33_i);
        rst_n_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk33_i);
            check("no_done_after_reset0", 32'(done_o[0]), 32'd0);
            check("no_done_after_reset1", 32'(done_o[1]), 32'd0);
        end
        run_event(1'b1, 8'h42, 32'h0BADBEEF, 16'h8001, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/anita3_event_header_writer.md
# anita3_event_header_writer

Builds the per-event header record and writes it into the 33 MHz event buffer RAM. On each accepted trigger it allocates a free buffer round-robin and writes eight 16-bit header words at addresses {buf,6'd0..6'd7}. It then pulses event_done so the buffer manager queues that buffer for readout. It also tracks buffer occupancy from release pulses, so that triggers never overwrite a buffer still awaiting readout.

## Interface
Parameters:
- NUM_BUFFERS, 4, number of event buffers in rotation; legal values 2 (dual-buffer-per-event mode) or 4.

Ports:
- clk33_i  in  1  33 MHz system clock; only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- trig_i  in  1  single-cycle trigger strobe.
- trig_type_i  in  8  trigger type, sampled with trig_i.
- trig_time_i  in  32  trigger timestamp, sampled with trig_i.
- trig_pattern_i  in  16  L3 pattern, sampled with trig_i.
- buf_release_i  in  1  pulse: oldest occupied buffer has been read out and cleared.
- event_wr_addr_o  out  8  {buf[1:0], word[5:0]} to the buffer RAM.
- event_wr_dat_o  out  16  header word.
- event_wr_o  out  1  RAM write strobe.
- event_done_o  out  1  one-cycle pulse; addr[7:6] holds the completed buffer.
- busy_o  out  1  a header write is in progress.
- full_o  out  1  occupancy == NUM_BUFFERS.
- occupancy_o  out  3  buffers written and not yet released.
- event_count_o  out  32  accepted events.
- drop_count_o  out  16  dropped triggers, saturating at 16'hFFFF.
- release_err_o  out  1  sticky flag: release received at occupancy 0.

## Operation
- The FSM has three states: IDLE, WRITE, DONE.
- IDLE: trig_i && !full_o causes accept. On accept, the block latches the inputs and the current event_count, sets buf = next_buf, clears word = 0, and goes to WRITE.
- WRITE: asserts event_wr_o with addr {buf, word}. word increments each cycle. After word 7 the FSM goes to DONE.
- DONE: event_done_o = 1 with addr {buf, 6'd0}. In this cycle:
  - occupancy increments;
  - next_buf = (next_buf == NUM_BUFFERS-1) ? 0 : next_buf+1;
  - event_count increments;
  - the FSM returns to IDLE.
- A trigger is dropped if it arrives when the FSM is not in IDLE, or when it arrives in IDLE with full_o set. A drop increments drop_count (saturating) and leaves every other output unchanged.
- Header words:
  - w0 = {4'hA, 2'b00, buf[1:0], trig_type}
  - w1 = event_count[15:0], w2 = event_count[31:16] (the count value latched at accept; the first event is 0)
  - w3 = time[15:0], w4 = time[31:16]
  - w5 = pattern
  - w6 = drop_count latched at accept
  - w7 = checksum (see Configuration).
- buf_release_i decrements occupancy.
- A release arriving in the same cycle as DONE leaves occupancy unchanged.
- A release at occupancy 0 is ignored and sets release_err_o. The flag clears only on reset.
- event_count wraps at 2^32.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, next_buf = 0, and all counters are 0. Reset is asynchronous.
- All outputs are registered.
- Latency for trig_i at cycle 0 with the FSM in IDLE and not full:
  - event_wr_o is high in cycles 1–8, with addr[5:0] = 0..7;
  - event_done_o is high in cycle 9;
  - busy_o is high in cycles 1–9;
  - the next trigger can be accepted at cycle 10.
- full_o and occupancy_o update in the cycle after DONE or after the release.
- Reset asserted mid-WRITE or mid-DONE: the write aborts, no event_done is issued, and occupancy returns to 0.

## Configuration
- EVENT_HEADER_CHECKSUM_EN defined: w7 = XOR of w0..w6, accumulated one word per WRITE cycle.
- EVENT_HEADER_CHECKSUM_EN undefined: w7 = 16'h0000, and no accumulator logic is generated.

## Structure
- Package anita3_evhdr_pkg holds:
  - the state enum (IDLE, WRITE, DONE);
  - localparams HDR_WORDS = 8, HDR_TAG = 4'hA;
  - word-index constants W_TAG … W_CSUM.
- The only sub-module is anita3_evhdr_checksum: a 16-bit running-XOR accumulator with clr/en/din inputs, instantiated under the macro.

## Test plan
- Single trigger (type 8'h5C, time 32'h12345678, pattern 16'hBEEF) after reset:
  - writes go to addr 0x00–0x07 with data A05C, 0000, 0000, 5678, 1234, BEEF, 0000, and w7 = XOR of those words (checksum macro defined);
  - event_done_o fires at cycle 9 with addr[7:6] = 0.
- Five triggers, with the bench waiting for each DONE and issuing no releases:
  - events 0–3 go to buffers 0, 1, 2, 3;
  - full_o = 1;
  - the 5th trigger is dropped, drop_count = 1, and no writes occur.
- Trigger asserted while busy, at cycle 3 of a write → that trigger is dropped. The next accepted event has w6 = 0001.
- release_i coincident with DONE at occupancy 2 → occupancy stays 2. A release at occupancy 0 sets release_err_o.
- NUM_BUFFERS = 2: three events with one release between them → buffers used are 0, 1, 0.
- rst_n_i pulsed low at WRITE word 4 → all outputs are 0 immediately with no event_done. A subsequent trigger writes to buffer 0 with event number 0.
